pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl - hazard and stall controller for a five-stage in-order pipeline.
//
// Produces the per-stage load enables and bubble (flush) controls for the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers plus the PC. It handles three
// kinds of event:
//   - memory stall  : MEM-stage access outstanding and not yet acknowledged
//   - branch taken  : EX resolved a taken branch/jump, squash IF and ID
//   - load-use      : ID reads a register that the load in EX is producing
// It also keeps two saturating performance counters.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   ID_RA1/2, ID_RA1/2_USED     ID-stage source addresses and use flags
//   EX_RC, EX_WERF, EX_IS_LD    EX-stage destination, write enable, load flag
//   EX_BR_TAKEN                 EX-stage branch resolved taken
//   MEM_REQ, MEM_READY          MEM-stage access pending / acknowledge
//   CNT_CLR                     synchronous clear of both counters
//   *_EN                        pipeline register / PC load enables
//   *_FLUSH                     load a bubble into that pipeline register
//   PC_REDIRECT                 PC takes the EX branch target
//   STALL_CNT, FLUSH_CNT        saturating performance counters
//   STATE                       current FSM state (INIT=0, RUN=1, MEM_WAIT=2)
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_RA1,
    input  logic [4:0]       ID_RA2,
    input  logic             ID_RA1_USED,
    input  logic             ID_RA2_USED,
    input  logic [4:0]       EX_RC,
    input  logic             EX_WERF,
    input  logic             EX_IS_LD,
    input  logic             EX_BR_TAKEN,
    input  logic             MEM_REQ,
    input  logic             MEM_READY,
    input  logic             CNT_CLR,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             MEM_WB_FLUSH,
    output logic             PC_REDIRECT,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic mem_stall;
    logic load_use;

    // Register 31 is the hardwired sink and never carries a real dependency.
    assign load_use = EX_IS_LD & EX_WERF & (EX_RC != 5'd31) &
                      ((ID_RA1_USED & (ID_RA1 == EX_RC)) |
                       (ID_RA2_USED & (ID_RA2 == EX_RC)));

    // A zero-wait access (ready together with request) is not a stall.
    assign mem_stall = MEM_REQ & ~MEM_READY;

    assign STATE = state;

    // Control outputs are combinational from the current state and inputs so
    // the pipeline reacts in the same cycle the hazard appears.
    always_comb begin
        // NOTE: every output gets a value before the case; without these
        // defaults an unassigned path would infer a latch.
        PC_EN        = 1'b1;
        IF_ID_EN     = 1'b1;
        ID_EX_EN     = 1'b1;
        EX_MEM_EN    = 1'b1;
        MEM_WB_EN    = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        MEM_WB_FLUSH = 1'b0;
        PC_REDIRECT  = 1'b0;
        state_nxt    = S_RUN;

        case (state)
            S_RUN, S_MEM_WAIT: begin
                if (mem_stall) begin
                    // Freeze everything; WB sees bubbles while MEM waits.
                    PC_EN        = 1'b0;
                    IF_ID_EN     = 1'b0;
                    ID_EX_EN     = 1'b0;
                    EX_MEM_EN    = 1'b0;
                    MEM_WB_EN    = 1'b0;
                    MEM_WB_FLUSH = 1'b1;
                    state_nxt    = S_MEM_WAIT;
                end else if (EX_BR_TAKEN) begin
                    // A branch held in EX across a memory wait is acted on
                    // here; EX advances this cycle so it fires only once.
                    // The ID instruction is squashed, so load-use is moot.
                    PC_REDIRECT = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, insert one bubble into ID/EX.
                    PC_EN       = 1'b0;
                    IF_ID_EN    = 1'b0;
                    ID_EX_FLUSH = 1'b1;
                end
            end
            default: begin
                // INIT (and the unused encoding): hold, flush, then run.
                PC_EN        = 1'b0;
                IF_ID_EN     = 1'b0;
                ID_EX_EN     = 1'b0;
                EX_MEM_EN    = 1'b0;
                MEM_WB_EN    = 1'b0;
                IF_ID_FLUSH  = 1'b1;
                ID_EX_FLUSH  = 1'b1;
                MEM_WB_FLUSH = 1'b1;
                state_nxt    = S_RUN;
            end
        endcase
    end

    logic stall_inc;
    logic flush_inc;

    assign stall_inc = ((state == S_RUN) || (state == S_MEM_WAIT)) && !PC_EN;
    assign flush_inc = PC_REDIRECT;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            state <= state_nxt;

            // Clear wins over increment; counters stick at all-ones.
            if (CNT_CLR)
                STALL_CNT <= '0;
            else if (stall_inc && (STALL_CNT != '1))
                STALL_CNT <= STALL_CNT + CNT_W'(1);

            if (CNT_CLR)
                FLUSH_CNT <= '0;
            else if (flush_inc && (FLUSH_CNT != '1))
                FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl - directed self-checking bench for pipe_ctrl.
// Two instances share all inputs: the default 16-bit counter build and a
// 4-bit counter build used to observe saturation.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered values 1 unit after the following edge.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_RA1, ID_RA2, EX_RC;
    logic        ID_RA1_USED, ID_RA2_USED;
    logic        EX_WERF, EX_IS_LD, EX_BR_TAKEN;
    logic        MEM_REQ, MEM_READY, CNT_CLR;

    logic        PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, PC_REDIRECT;
    logic [15:0] STALL_CNT, FLUSH_CNT;
    logic [1:0]  STATE;

    logic        w4_pc_en, w4_if_id_en, w4_id_ex_en, w4_ex_mem_en, w4_mem_wb_en;
    logic        w4_if_id_flush, w4_id_ex_flush, w4_mem_wb_flush, w4_pc_redirect;
    logic [3:0]  w4_stall_cnt, w4_flush_cnt;
    logic [1:0]  w4_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_RA1(ID_RA1), .ID_RA2(ID_RA2),
        .ID_RA1_USED(ID_RA1_USED), .ID_RA2_USED(ID_RA2_USED),
        .EX_RC(EX_RC), .EX_WERF(EX_WERF), .EX_IS_LD(EX_IS_LD),
        .EX_BR_TAKEN(EX_BR_TAKEN),
        .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY), .CNT_CLR(CNT_CLR),
        .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN),
        .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
        .MEM_WB_FLUSH(MEM_WB_FLUSH), .PC_REDIRECT(PC_REDIRECT),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .STATE(STATE)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .ID_RA1(ID_RA1), .ID_RA2(ID_RA2),
        .ID_RA1_USED(ID_RA1_USED), .ID_RA2_USED(ID_RA2_USED),
        .EX_RC(EX_RC), .EX_WERF(EX_WERF), .EX_IS_LD(EX_IS_LD),
        .EX_BR_TAKEN(EX_BR_TAKEN),
        .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY), .CNT_CLR(CNT_CLR),
        .PC_EN(w4_pc_en), .IF_ID_EN(w4_if_id_en), .ID_EX_EN(w4_id_ex_en),
        .EX_MEM_EN(w4_ex_mem_en), .MEM_WB_EN(w4_mem_wb_en),
        .IF_ID_FLUSH(w4_if_id_flush), .ID_EX_FLUSH(w4_id_ex_flush),
        .MEM_WB_FLUSH(w4_mem_wb_flush), .PC_REDIRECT(w4_pc_redirect),
        .STALL_CNT(w4_stall_cnt), .FLUSH_CNT(w4_flush_cnt), .STATE(w4_state)
    );

    // {PC, IF/ID, ID/EX, EX/MEM, MEM/WB} enables and {IF/ID, ID/EX, MEM/WB} flushes
    logic [4:0] en;
    logic [2:0] fl;
    assign en = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN};
    assign fl = {IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_RA1 = 5'd0; ID_RA2 = 5'd0; ID_RA1_USED = 1'b0; ID_RA2_USED = 1'b0;
        EX_RC = 5'd0; EX_WERF = 1'b0; EX_IS_LD = 1'b0; EX_BR_TAKEN = 1'b0;
        MEM_REQ = 1'b0; MEM_READY = 1'b0; CNT_CLR = 1'b0;
    endtask

    task automatic clear_counters();
        CNT_CLR = 1'b1;
        step();
        CNT_CLR = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rc);
        EX_IS_LD = 1'b1; EX_WERF = 1'b1; EX_RC = rc;
        ID_RA2 = rc; ID_RA2_USED = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        // In reset: INIT outputs, counters zero, across clock edges too.
        check("rst_state", STATE, 2'd0);
        check("rst_en", en, 5'b00000);
        check("rst_fl", fl, 3'b111);
        check("rst_redirect", PC_REDIRECT, 1'b0);
        step(); step();
        check("rst_hold_state", STATE, 2'd0);
        check("rst_cnt", {STALL_CNT, FLUSH_CNT}, 32'd0);

        // Release: one INIT cycle, then RUN with everything enabled.
        reset = 1'b0;
        #1;
        check("init_cycle_state", STATE, 2'd0);
        check("init_cycle_en", en, 5'b00000);
        check("init_cycle_fl", fl, 3'b111);
        step();
        check("run_state", STATE, 2'd1);
        check("run_en", en, 5'b11111);
        check("run_fl", fl, 3'b000);
        check("run_cnt", {STALL_CNT, FLUSH_CNT}, 32'd0);

        // Load-use on RA2 = r5: hold PC/IF-ID, bubble ID/EX.
        set_load_use(5'd5);
        #1;
        check("lu_en", en, 5'b00111);
        check("lu_fl", fl, 3'b010);
        check("lu_redirect", PC_REDIRECT, 1'b0);
        step();
        idle_inputs();
        #1;
        check("lu_stall_cnt", STALL_CNT, 16'd1);
        check("lu_after_en", en, 5'b11111);

        // r31 never hazards.
        set_load_use(5'd31);
        #1;
        check("lu_r31_en", en, 5'b11111);
        step();
        // Matching address but source unused, and non-writing load: no stall.
        idle_inputs();
        EX_IS_LD = 1'b1; EX_WERF = 1'b1; EX_RC = 5'd7; ID_RA1 = 5'd7; ID_RA1_USED = 1'b0;
        #1;
        check("lu_unused_en", en, 5'b11111);
        ID_RA1_USED = 1'b1; EX_WERF = 1'b0;
        #1;
        check("lu_nowe_en", en, 5'b11111);
        EX_WERF = 1'b1;
        #1;
        check("lu_ra1_en", en, 5'b00111);
        step();
        idle_inputs();
        #1;
        check("lu_ra1_cnt", STALL_CNT, 16'd2);

        // Memory stall for three cycles, then ready.
        clear_counters();
        #1;
        check("clr_cnt", {STALL_CNT, FLUSH_CNT}, 32'd0);
        MEM_REQ = 1'b1; MEM_READY = 1'b0;
        #1;
        check("ms1_state", STATE, 2'd1);
        check("ms1_en", en, 5'b00000);
        check("ms1_fl", fl, 3'b001);
        step();
        check("ms2_state", STATE, 2'd2);
        check("ms2_en", en, 5'b00000);
        check("ms2_fl", fl, 3'b001);
        step();
        check("ms3_state", STATE, 2'd2);
        check("ms3_en", en, 5'b00000);
        step();
        MEM_READY = 1'b1;
        #1;
        check("ms_rel_en", en, 5'b11111);
        check("ms_rel_fl", fl, 3'b000);
        step();
        check("ms_rel_state", STATE, 2'd1);
        check("ms_stall_cnt", STALL_CNT, 16'd3);

        // Zero-wait access never enters MEM_WAIT.
        #1;
        check("zw_en", en, 5'b11111);
        step();
        check("zw_state", STATE, 2'd1);
        check("zw_cnt", STALL_CNT, 16'd3);
        idle_inputs();

        // Branch held through a memory wait fires exactly once on ready.
        clear_counters();
        MEM_REQ = 1'b1; MEM_READY = 1'b0; EX_BR_TAKEN = 1'b1;
        #1;
        check("bw_stall_redirect", PC_REDIRECT, 1'b0);
        check("bw_stall_en", en, 5'b00000);
        step();
        MEM_READY = 1'b1;
        #1;
        check("bw_rel_redirect", PC_REDIRECT, 1'b1);
        check("bw_rel_en", en, 5'b11111);
        check("bw_rel_fl", fl, 3'b110);
        step();
        idle_inputs();
        #1;
        check("bw_flush_cnt", FLUSH_CNT, 16'd1);
        check("bw_stall_cnt", STALL_CNT, 16'd1);
        check("bw_state", STATE, 2'd1);

        // Branch together with load-use: branch wins, no stall counted.
        clear_counters();
        set_load_use(5'd5);
        EX_BR_TAKEN = 1'b1;
        #1;
        check("blu_redirect", PC_REDIRECT, 1'b1);
        check("blu_en", en, 5'b11111);
        check("blu_fl", fl, 3'b110);
        step();
        idle_inputs();
        #1;
        check("blu_flush_cnt", FLUSH_CNT, 16'd1);
        check("blu_stall_cnt", STALL_CNT, 16'd0);

        // 20 consecutive load-use cycles: 4-bit counter saturates at 15.
        clear_counters();
        set_load_use(5'd9);
        for (int i = 0; i < 20; i++) step();
        check("sat_w4", w4_stall_cnt, 4'd15);
        check("sat_w16", STALL_CNT, 16'd20);
        // Clear wins over a stall in the same cycle.
        CNT_CLR = 1'b1;
        step();
        check("clr_pri_w4", w4_stall_cnt, 4'd0);
        check("clr_pri_w16", STALL_CNT, 16'd0);
        idle_inputs();

        // Reset in the middle of a memory wait abandons it immediately.
        MEM_REQ = 1'b1; MEM_READY = 1'b0;
        step();
        check("rw_state_wait", STATE, 2'd2);
        MEM_READY = 1'b1;
        reset = 1'b1;
        #1;
        check("rw_async_state", STATE, 2'd0);
        check("rw_async_en", en, 5'b00000);
        check("rw_async_cnt", {STALL_CNT, FLUSH_CNT}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rw_init_state", STATE, 2'd0);
        check("rw_init_fl", fl, 3'b111);
        step();
        check("rw_run_state", STATE, 2'd1);
        check("rw_run_en", en, 5'b11111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
